// File: rtl/rvcpu.sv
// rvcpu: shared core types plus constants for the prefetching IF stage
package rvcpu;
    localparam int PC_W   = 32;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    typedef logic [PC_W-1:0]   pc_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef struct packed {
        pc_t   pc;
        data_t opcode;
    } stage_if_t;
    localparam pc_t IF_PC_STEP = pc_t'(4);
    typedef enum logic [1:0] {BOOT, FETCH, HALT} if_state_e;
endpackage

// File: rtl/stage_if_prefetch_if.sv
// stage_if_prefetch_if: redirect, memory and ID-side handshakes of the prefetch IF stage
// RVCPU_IF_MISALIGN_EN adds misalign_o
interface stage_if_prefetch_if;
    import rvcpu::*;
    logic      redirect_i;
    pc_t       redirect_pc_i;
    logic      mem_req_valid;
    logic      mem_req_ready;
    addr_t     mem_req_addr;
    logic      mem_rsp_valid;
    data_t     mem_rsp_data;
    logic      out_valid;
    logic      out_ready;
    stage_if_t out;
`ifdef RVCPU_IF_MISALIGN_EN
    logic      misalign_o;
    modport master (
        input  redirect_i, redirect_pc_i, mem_req_ready, mem_rsp_valid, mem_rsp_data, out_ready,
        output mem_req_valid, mem_req_addr, out_valid, out, misalign_o
    );
    modport slave (
        output redirect_i, redirect_pc_i, mem_req_ready, mem_rsp_valid, mem_rsp_data, out_ready,
        input  mem_req_valid, mem_req_addr, out_valid, out, misalign_o
    );
`else
    modport master (
        input  redirect_i, redirect_pc_i, mem_req_ready, mem_rsp_valid, mem_rsp_data, out_ready,
        output mem_req_valid, mem_req_addr, out_valid, out
    );
    modport slave (
        output redirect_i, redirect_pc_i, mem_req_ready, mem_rsp_valid, mem_rsp_data, out_ready,
        input  mem_req_valid, mem_req_addr, out_valid, out
    );
`endif
endinterface

// File: rtl/rvcpu_sync_fifo.sv
// rvcpu_sync_fifo: synchronous FIFO with flush and occupancy count; DEPTH must be a power of 2
module rvcpu_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic             wr, rd;
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    // a push into a full queue is only taken when the head leaves in the same cycle
    assign wr    = push && (!full || pop) && !flush;
    assign rd    = pop && !empty && !flush;
    assign dout  = mem[rp];
    always_ff @(posedge clk) begin
        if (wr) mem[wp] <= din;
    end
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (wr) wp <= wp + 1'b1;
            if (rd) rp <= rp + 1'b1;
            count <= count + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end
endmodule

// File: rtl/stage_if_prefetch.sv
// stage_if_prefetch: prefetching IF stage with credit-limited memory port and redirect flush
// Optional RVCPU_IF_MISALIGN_EN: a misaligned redirect halts fetch and emits one flagged entry
module stage_if_prefetch
    import rvcpu::*;
#(
    parameter int  FIFO_DEPTH      = 4,
    parameter int  MAX_OUTSTANDING = 2,
    parameter pc_t RESET_PC        = '0
) (
    input logic                 clk,
    input logic                 rst,
    stage_if_prefetch_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef RVCPU_IF_MISALIGN_EN
    localparam int EW = $bits(stage_if_t) + 1;
`else
    localparam int EW = $bits(stage_if_t);
`endif
    localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] MAXO_C  = CW'(MAX_OUTSTANDING);

    if_state_e     state, state_nx;
    pc_t           fetch_pc, rsp_pc, rpc;
    logic [CW-1:0] outstanding, discard, count;
    logic          mis_rd, mis_pend, acc, rsp, drop, push_rsp, push_mis, push, pop, full, empty;
    stage_if_t     ins, head_ins;
    logic [EW-1:0] din, dout;

`ifdef RVCPU_IF_MISALIGN_EN
    logic head_mis;
    assign rpc                  = bus.redirect_pc_i;
    assign mis_rd               = |bus.redirect_pc_i[1:0];
    assign din                  = {push_mis, ins};
    assign {head_mis, head_ins} = dout;
    assign bus.misalign_o       = bus.out_valid && head_mis;
`else
    assign rpc      = bus.redirect_pc_i & ~pc_t'(3);
    assign mis_rd   = 1'b0;
    assign din      = ins;
    assign head_ins = dout;
`endif

    assign acc      = bus.mem_req_valid && bus.mem_req_ready;
    assign rsp      = bus.mem_rsp_valid;
    assign drop     = rsp && discard != '0;
    assign push_rsp = rsp && discard == '0 && !bus.redirect_i;
    // once every stale response has drained, the halted PC is reported as a single entry
    assign push_mis = mis_pend && discard == '0 && !bus.redirect_i;
    assign push     = push_rsp || push_mis;
    assign pop      = bus.out_valid && bus.out_ready;
    assign ins      = push_mis ? stage_if_t'{pc: fetch_pc, opcode: '0}
                               : stage_if_t'{pc: rsp_pc, opcode: bus.mem_rsp_data};

    always_comb begin
        state_nx          = bus.redirect_i ? (mis_rd ? HALT : FETCH) : (state == BOOT ? FETCH : state);
        bus.mem_req_valid = state == FETCH && !bus.redirect_i && outstanding < MAXO_C &&
                            ({1'b0, outstanding} + {1'b0, count}) < DEPTH_C;
        bus.mem_req_addr  = bus.mem_req_valid ? addr_t'(fetch_pc) : '0;
        bus.out_valid     = !empty && !bus.redirect_i;
        bus.out           = bus.out_valid ? head_ins : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            mis_pend    <= 1'b0;
        end else begin
            state       <= state_nx;
            outstanding <= outstanding + CW'(acc) - CW'(rsp);
            if (bus.redirect_i) begin
                fetch_pc <= rpc;
                rsp_pc   <= rpc;
                discard  <= outstanding - CW'(rsp);
                mis_pend <= mis_rd;
            end else begin
                if (acc)      fetch_pc <= fetch_pc + IF_PC_STEP;
                if (push_rsp) rsp_pc   <= rsp_pc + IF_PC_STEP;
                if (drop)     discard  <= discard - 1'b1;
                if (push_mis) mis_pend <= 1'b0;
            end
        end
    end

    rvcpu_sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .flush(bus.redirect_i),
        .din  (din),
        .dout (dout),
        .count(count),
        .full (full),
        .empty(empty)
    );

    assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));
    assert property (@(posedge clk) disable iff (rst) outstanding <= MAXO_C);
endmodule

// File: tb/tb_stage_if_prefetch.sv
// tb_stage_if_prefetch: random memory/ID traffic against a scoreboard of expected fetch stream
module tb_stage_if_prefetch;
    import rvcpu::*;
    localparam pc_t RST_PC = 32'h100;
    typedef struct { pc_t pc; logic mis; } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    stage_if_prefetch_if bus();
    stage_if_prefetch #(.FIFO_DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(RST_PC)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;

    exp_t  exp_q[$];
    addr_t mem_q[$];
    pc_t   exp_addr = RST_PC;
    pc_t   first_pc = '0;
    pc_t   a0;
    int    n_chk = 0, n_fail = 0, n_pop = 0;
    int    p_ready = 100, p_rsp = 0, p_oready = 100;
    logic  halted = 1'b0, cap = 1'b0;

    function automatic data_t op_of(pc_t a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic roll(int p);
        return int'($urandom_range(99)) < p;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // every word fetched before a redirect is stale; the stream restarts at the (aligned) target
    task automatic model_redirect(pc_t pc);
        exp_q.delete();
        halted   = 1'b0;
        exp_addr = pc & ~pc_t'(3);
`ifdef RVCPU_IF_MISALIGN_EN
        if (pc[1:0] != 2'b00) begin
            exp_q.push_back('{pc, 1'b1});
            halted   = 1'b1;
            exp_addr = pc;
        end
`endif
    endtask

    task automatic cycle();
        @(negedge clk);
        if (!rst) begin
            if (bus.redirect_i) begin
                chk("redirect_no_req", bus.mem_req_valid, 0);
                chk("redirect_out_valid", bus.out_valid, 0);
            end
`ifdef RVCPU_IF_MISALIGN_EN
            if (halted && !bus.redirect_i) chk("halt_no_req", bus.mem_req_valid, 0);
`endif
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                chk("req_addr", bus.mem_req_addr, exp_addr);
                mem_q.push_back(bus.mem_req_addr);
                exp_q.push_back('{bus.mem_req_addr, 1'b0});
                exp_addr += 4;
            end
            if (bus.redirect_i) model_redirect(bus.redirect_pc_i);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            mem_q.delete();
            exp_q.delete();
            exp_addr = RST_PC;
            halted   = 1'b0;
        end
        bus.redirect_i    = 1'b0;
        bus.mem_req_ready = roll(p_ready);
        bus.out_ready     = roll(p_oready);
        if (!rst && mem_q.size() > 0 && roll(p_rsp)) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = op_of(mem_q.pop_front());
        end else begin
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rsp_data  = $urandom;
        end
    endtask

    task automatic redirect(pc_t pc);
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = pc;
        cap               = 1'b1;
    endtask

    task automatic expect_first(string name, pc_t pc);
        for (int i = 0; i < 40 && cap; i++) cycle();
        chk(name, {cap, first_pc}, {1'b0, pc});
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                n_pop++;
                if (cap) begin
                    first_pc = bus.out.pc;
                    cap      = 1'b0;
                end
                if (exp_q.size() == 0) chk("out_extra", bus.out.pc, '1);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_pc", bus.out.pc, e.pc);
                    if (!e.mis) chk("out_opcode", bus.out.opcode, op_of(e.pc));
`ifdef RVCPU_IF_MISALIGN_EN
                    chk("out_misalign", bus.misalign_o, e.mis);
`endif
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        bus.out_ready     = 1'b0;
        repeat (2) cycle();
        chk("rst_req_valid", bus.mem_req_valid, 0);
        chk("rst_req_addr", bus.mem_req_addr, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out", bus.out, 0);
        // first word latency from the response cycle
        rst = 1'b0;
        for (int i = 0; i < 10 && mem_q.size() == 0; i++) cycle();
        chk("t1_first_req", mem_q.size(), 1);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = op_of(mem_q.pop_front());
        #1;
        chk("t1_not_yet_valid", bus.out_valid, 0);
        cycle();
        chk("t1_latency_valid", bus.out_valid, 1);
        chk("t1_latency_pc", bus.out.pc, RST_PC);
        p_ready = 70; p_rsp = 60; p_oready = 70;
        repeat (300) cycle();
        // ID stall: queue fills to depth and fetching stops
        p_ready = 100; p_rsp = 100; p_oready = 0;
        repeat (20) cycle();
        chk("t2_buffered", exp_q.size(), 4);
        chk("t2_mem_idle", mem_q.size(), 0);
        chk("t2_req_blocked", bus.mem_req_valid, 0);
        p_oready = 100;
        n0 = n_pop;
        repeat (8) cycle();
        chk("t2_release_pops", n_pop - n0 >= 4, 1);
        // two outstanding requests killed by a redirect
        p_ready = 0;
        repeat (6) cycle();
        p_ready = 100; p_rsp = 0;
        cycle();
        redirect(32'h200);
        cycle();
        for (int i = 0; i < 10 && mem_q.size() < 2; i++) cycle();
        chk("t3_two_outstanding", mem_q.size(), 2);
        redirect(32'h400);
        p_rsp = 100;
        cycle();
        expect_first("t3_first_pc", 32'h400);
        // redirect on a cycle with a response and an ID handshake
        for (int i = 0; i < 20 && !(bus.mem_rsp_valid && bus.out_valid && bus.out_ready); i++) cycle();
        chk("t4_setup", bus.mem_rsp_valid && bus.out_valid && bus.out_ready, 1);
        redirect(32'h600);
        #1;
        chk("t4_out_valid_low", bus.out_valid, 0);
        cycle();
        expect_first("t4_first_pc", 32'h600);
        // memory back-pressure keeps the address stable; then reset mid-burst
        p_ready = 0;
        cycle();
        for (int i = 0; i < 10 && !bus.mem_req_valid; i++) cycle();
        chk("t5_req_valid", bus.mem_req_valid, 1);
        a0 = bus.mem_req_addr;
        repeat (5) begin
            cycle();
            chk("t5_addr_stable", {bus.mem_req_valid, bus.mem_req_addr}, {1'b1, a0});
        end
        p_ready = 100;
        repeat (4) cycle();
        rst = 1'b1;
        cycle();
        chk("t5_rst_req_valid", bus.mem_req_valid, 0);
        chk("t5_rst_req_addr", bus.mem_req_addr, 0);
        chk("t5_rst_out_valid", bus.out_valid, 0);
        chk("t5_rst_out", bus.out, 0);
        rst = 1'b0;
        cap = 1'b1;
        expect_first("t5_restart_pc", RST_PC);
        // misaligned redirect
        redirect(32'h402);
        cycle();
`ifdef RVCPU_IF_MISALIGN_EN
        expect_first("t6_misalign_pc", 32'h402);
        repeat (5) cycle();
        redirect(32'h500);
        cycle();
        expect_first("t6_resume_pc", 32'h500);
`else
        expect_first("t6_aligned_pc", 32'h400);
`endif
        // random traffic with random aligned redirects
        p_ready = 75; p_rsp = 65; p_oready = 75;
        for (int i = 0; i < 400; i++) begin
            cycle();
            if (roll(4)) redirect(32'h1000 + ($urandom_range(1023) << 2));
        end
        cap = 1'b0;
        p_ready = 0; p_rsp = 100; p_oready = 100;
        repeat (20) cycle();
        chk("drain_exp_empty", exp_q.size(), 0);
        chk("drain_mem_empty", mem_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
